// File: rtl/rst_sequencer.sv
// Reset release sequencer: stretches RST, then releases active-low RST_OUT bits in order; RST_SEQ_SW_REQ_EN adds SW replay.
// Latency: RST_OUT[i] rises HOLD_CYCLES + i*STAGE_GAP edges after RST drops; SW ACK one edge after REQ is sampled in DONE.
// Backpressure: none; SW_RST_REQ is level-sampled only in DONE and ignored elsewhere.
module rst_sequencer #(
  parameter int NUM_OUTS    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  output logic                SW_RST_ACK,
  output logic [NUM_OUTS-1:0] RST_OUT,
  output logic                SEQ_DONE
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_OUTS + 1);

  localparam logic [CNT_W-1:0]    HOLD_C   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]    STAGE_C  = CNT_W'(STAGE_GAP);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_OUTS - 1);
  localparam logic [NUM_OUTS-1:0] BIT0     = NUM_OUTS'(1);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_OUTS-1:0] rst_out_q, rst_out_d;
  logic                seq_done_q, seq_done_d;
  logic                sw_ack_q, sw_ack_d;

`ifdef RST_SEQ_SW_REQ_EN
  // A request sampled in DONE is held one edge, then replays the sequence.
  logic                sw_pend_q, sw_pend_d;
`else
  logic                unused_sw_req;
  assign unused_sw_req = SW_RST_REQ;
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    seq_done_d = seq_done_q;
    sw_ack_d   = 1'b0;
`ifdef RST_SEQ_SW_REQ_EN
    sw_pend_d  = 1'b0;
`endif
    case (state_q)
      S_HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_inc == HOLD_C) begin
          rst_out_d = rst_out_q | BIT0;
          cnt_d     = '0;
          idx_d     = IDX_W'(1);
          if (NUM_OUTS == 1) begin
            seq_done_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d    = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == STAGE_C) begin
          rst_out_d = rst_out_q | (BIT0 << idx_q);
          cnt_d     = '0;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            seq_done_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
`ifdef RST_SEQ_SW_REQ_EN
        if (sw_pend_q) begin
          rst_out_d  = '0;
          seq_done_d = 1'b0;
          sw_ack_d   = 1'b1;
          cnt_d      = '0;
          idx_d      = '0;
          state_d    = S_HOLD;
        end else if (SW_RST_REQ) begin
          sw_pend_d  = 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '0;
      seq_done_q <= 1'b0;
      sw_ack_q   <= 1'b0;
`ifdef RST_SEQ_SW_REQ_EN
      sw_pend_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
      sw_ack_q   <= sw_ack_d;
`ifdef RST_SEQ_SW_REQ_EN
      sw_pend_q  <= sw_pend_d;
`endif
    end
  end

  assign RST_OUT    = rst_out_q;
  assign SEQ_DONE   = seq_done_q;
  assign SW_RST_ACK = sw_ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: vector table, hand-written corner sequences and random traffic against an elapsed-time model.
module tb_rst_sequencer;

  localparam int N0 = 3, H0 = 16, G0 = 8;
  localparam int N1 = 1, H1 = 1,  G1 = 1;
`ifdef RST_SEQ_SW_REQ_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [2:0] out0;
  logic       done0, ack0;
  logic [0:0] out1;
  logic       done1, ack1;

  always #5 clk = ~clk;

  rst_sequencer #(.NUM_OUTS(N0), .HOLD_CYCLES(H0), .STAGE_GAP(G0)) dut0 (
    .clk(clk), .RST(rst), .SW_RST_REQ(req), .SW_RST_ACK(ack0), .RST_OUT(out0), .SEQ_DONE(done0));
  rst_sequencer #(.NUM_OUTS(N1), .HOLD_CYCLES(H1), .STAGE_GAP(G1)) dut1 (
    .clk(clk), .RST(rst), .SW_RST_REQ(req), .SW_RST_ACK(ack1), .RST_OUT(out1), .SEQ_DONE(done1));

  int compared = 0;
  int mismatched = 0;

  // Model: t = edges elapsed since the sequence (re)started, saturating once all bits are out.
  int t[2];
  bit pend[2];
  bit mack[2];

  function automatic int nouts(input int k);  return (k == 0) ? N0 : N1; endfunction
  function automatic int hold(input int k);   return (k == 0) ? H0 : H1; endfunction
  function automatic int gap(input int k);    return (k == 0) ? G0 : G1; endfunction
  function automatic int last_edge(input int k);
    return hold(k) + (nouts(k) - 1) * gap(k);
  endfunction

  function automatic logic [2:0] exp_out(input int k);
    logic [2:0] e;
    e = '0;
    for (int i = 0; i < nouts(k); i++) e[i] = (t[k] >= hold(k) + i * gap(k));
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit q);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        t[k] = 0; pend[k] = 1'b0; mack[k] = 1'b0;
      end else if (pend[k]) begin
        t[k] = 0; pend[k] = 1'b0; mack[k] = 1'b1;
      end else begin
        mack[k] = 1'b0;
        if (t[k] >= last_edge(k)) begin
          if (q && SW_EN) pend[k] = 1'b1;
        end else begin
          t[k] = t[k] + 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h (t=%0d)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit q);
    logic [2:0] e0, e1;
    rst = r;
    req = q;
    @(posedge clk);
    model_edge(r, q);
    #1;
    e0 = exp_out(0);
    e1 = exp_out(1);
    check("model_out0",  32'(out0),    32'(e0));
    check("model_done0", 32'(done0),   32'(t[0] >= last_edge(0)));
    check("model_ack0",  32'(ack0),    32'(mack[0]));
    check("model_out1",  32'(out1),    32'(e1[0]));
    check("model_done1", 32'(done1),   32'(t[1] >= last_edge(1)));
    check("model_ack1",  32'(ack1),    32'(mack[1]));
  endtask

  typedef struct {
    bit         r;
    bit         q;
    int         n;
    logic [2:0] eo;
    bit         ed;
    bit         ea;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit q, input int n, input logic [2:0] eo, input bit ed, input bit ea);
    vec_t v;
    v.r = r; v.q = q; v.n = n; v.eo = eo; v.ed = ed; v.ea = ea;
    tbl.push_back(v);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin t[k] = 0; pend[k] = 1'b0; mack[k] = 1'b0; end

    // Reset state, then the single-output / HOLD_CYCLES=1 instance releases on edge 1.
    repeat (3) step(1'b1, 1'b0);
    check("reset_out0",  32'(out0),  32'h0);
    check("reset_done0", 32'(done0), 32'h0);
    check("reset_ack0",  32'(ack0),  32'h0);
    check("reset_out1",  32'(out1),  32'h0);
    step(1'b0, 1'b0);
    check("small_out_edge1",  32'(out1),  32'h1);
    check("small_done_edge1", 32'(done1), 32'h1);

    // Power-up release timing 16/24/32.
    add(1, 0, 5,  3'b000, 0, 0);
    add(0, 0, 15, 3'b000, 0, 0);
    add(0, 0, 1,  3'b001, 0, 0);
    add(0, 0, 7,  3'b001, 0, 0);
    add(0, 0, 1,  3'b011, 0, 0);
    add(0, 0, 7,  3'b011, 0, 0);
    add(0, 0, 1,  3'b111, 1, 0);
    add(0, 0, 4,  3'b111, 1, 0);
    // Mid-sequence reset at edge 20, dropped so edge 23 is the new edge 1.
    add(1, 0, 5,  3'b000, 0, 0);
    add(0, 0, 19, 3'b001, 0, 0);
    add(1, 0, 1,  3'b000, 0, 0);
    add(1, 0, 2,  3'b000, 0, 0);
    add(0, 0, 15, 3'b000, 0, 0);
    add(0, 0, 1,  3'b001, 0, 0);
    // Request during HOLD at edge 10 is ignored.
    add(1, 0, 5,  3'b000, 0, 0);
    add(0, 0, 9,  3'b000, 0, 0);
    add(0, 1, 1,  3'b000, 0, 0);
    add(0, 0, 5,  3'b000, 0, 0);
    add(0, 0, 1,  3'b001, 0, 0);
    add(0, 0, 7,  3'b001, 0, 0);
    add(0, 0, 1,  3'b011, 0, 0);
    add(0, 0, 8,  3'b111, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].n) step(tbl[i].r, tbl[i].q);
      check($sformatf("vec%0d_out", i),  32'(out0),  32'(tbl[i].eo));
      check($sformatf("vec%0d_done", i), 32'(done0), 32'(tbl[i].ed));
      check($sformatf("vec%0d_ack", i),  32'(ack0),  32'(tbl[i].ea));
    end

`ifdef RST_SEQ_SW_REQ_EN
    // One-cycle request at edge n in DONE: ACK and clear at n+1, replay at n+17/n+25/n+33.
    step(1'b0, 1'b1);
    check("sw_n_ack",   32'(ack0),  32'h0);
    check("sw_n_out",   32'(out0),  32'h7);
    step(1'b0, 1'b0);
    check("sw_n1_ack",  32'(ack0),  32'h1);
    check("sw_n1_out",  32'(out0),  32'h0);
    check("sw_n1_done", 32'(done0), 32'h0);
    step(1'b0, 1'b0);
    check("sw_n2_ack",  32'(ack0),  32'h0);
    repeat (14) step(1'b0, 1'b0);
    check("sw_n16_out", 32'(out0),  32'h0);
    step(1'b0, 1'b0);
    check("sw_n17_out", 32'(out0),  32'h1);
    repeat (8) step(1'b0, 1'b0);
    check("sw_n25_out", 32'(out0),  32'h3);
    repeat (8) step(1'b0, 1'b0);
    check("sw_n33_out",  32'(out0),  32'h7);
    check("sw_n33_done", 32'(done0), 32'h1);
    // RST together with REQ: RST wins, no ACK.
    rst = 1'b1; req = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("rst_wins_ack", 32'(ack0), 32'h0);
    check("rst_wins_out", 32'(out0), 32'h0);
`else
    // Without the handshake, DONE is terminal.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      check("nosw_ack", 32'(ack0), 32'h0);
      check("nosw_out", 32'(out0), 32'h7);
    end
    step(1'b0, 1'b0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
